mem_access: RTL and testbench
=============================

# mem_access

Memory-stage data-bus access unit. Consumes the memory-stage instruction after the misalignment checker has produced `is_exception`, issues a single data-bus request (store strobes/data or load), holds the pipeline via `stall` until the bus answers, and delivers an aligned, sign/zero-extended load result to writeback. Faulting or non-memory instructions pass through with no bus activity.

## Interface
Parameters: none (64-bit datapath, 8-byte bus, fixed).

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `in_valid`  in  1  memory-stage instruction valid this cycle
- `addr`  in  64  effective address
- `memread` / `memwrite`  in  1 each  load / store (never both)
- `msize`  in  msize_t  MSIZE1/2/4/8
- `mem_unsigned`  in  1  zero-extend load (LBU/LHU/LWU)
- `wdata`  in  64  store data, right-aligned
- `is_exception`  in  1  misalignment result for this instruction; suppresses access
- `flush`  in  1  kill current memory-stage instruction
- `dreq_valid`  out  1  bus request valid
- `dreq_addr`  out  64  request address (= `addr`, unmodified)
- `dreq_size`  out  msize_t  request size
- `dreq_strobe`  out  8  byte-write enables (0 for loads)
- `dreq_data`  out  64  lane-shifted store data
- `dresp_data_ok`  in  1  bus completion
- `dresp_data`  in  64  raw 8-byte read lane
- `stall`  out  1  hold memory stage and upstream
- `done`  out  1  one-cycle completion pulse
- `rdata`  out  64  extended load result, valid with `done`

## Operation
- `launch = in_valid & (memread|memwrite) & ~is_exception & ~flush & state==IDLE`.
- States: IDLE, REQ, DONE.
  - IDLE: on `launch` latch addr/size/strobe/data/unsigned/read flag, go REQ. Else stay.
  - REQ: `dreq_valid`=1, all dreq fields stable from latches. On `dresp_data_ok` -> DONE, or -> IDLE if killed.
  - DONE: `done`=1 for this cycle only, `rdata` holds result; -> IDLE unconditionally (never launches in DONE; the same instruction is still on the inputs).
- `stall = launch | (state==REQ)`; 0 in DONE.
- Strobe: MSIZE1 `8'h01`, MSIZE2 `8'h03`, MSIZE4 `8'h0F`, MSIZE8 `8'hFF`, each `<< addr[2:0]`, truncated to 8 bits; loads drive 0.
- Store data: `wdata << (8*addr[2:0])`, truncated to 64.
- Load: `sh = dresp_data >> (8*addr[2:0])`; take low 8/16/32/64 bits by size; sign-extend from top bit unless `mem_unsigned`; MSIZE8 ignores `mem_unsigned`. Registered into `rdata` on the `dresp_data_ok` cycle; stores leave `rdata` unchanged.
- No boundary splitting and no alignment recheck; misaligned accesses are blocked by `is_exception` upstream.
- Flush: in IDLE blocks launch. In REQ, bus transactions are not abortable: set `killed`, keep `dreq_valid` until `dresp_data_ok`, then IDLE with no `done` and no `rdata` update. `stall` stays high through REQ.
- `is_exception` is only sampled in IDLE.

## Timing
- Reset (sync, next edge, any state incl. REQ): state IDLE, `dreq_valid`=0, `dreq_addr`=0, `dreq_size`=MSIZE1, `dreq_strobe`=0, `dreq_data`=0, `done`=0, `rdata`=0, `killed`=0; `stall`=0 unless `launch`.
- Cycle 0: launch seen, `stall`=1. Cycle 1: REQ, `dreq_valid`=1. `dresp_data_ok` at cycle k≥1 -> cycle k+1 DONE, `done`=1, `stall`=0. Minimum stall 2 cycles (data_ok in cycle 1).
- `dresp_data_ok` ignored outside REQ.
- Back-to-back accesses: earliest next launch is the cycle after DONE.

## Test plan
- SW at `addr=0x1004`, `wdata=0x11223344`, data_ok 3 cycles after valid -> `dreq_strobe=8'hF0`, `dreq_data=0x11223344_00000000`, `dreq_size=MSIZE4`; `stall` high 4 cycles, one `done` pulse.
- LB at `addr=0x2003`, `dresp_data=0x00000000_80000000`, data_ok in cycle 1 -> `rdata=0xFFFFFFFF_FFFFFF80`, stall exactly 2 cycles; repeat with `mem_unsigned=1` -> `rdata=0x80`.
- LD `addr=0x3000`, `dresp_data=0xDEADBEEF_CAFEF00D` -> `rdata` identical, strobe 0.
- LH with `is_exception=1` -> `dreq_valid`, `stall`, `done` all stay 0.
- Flush asserted mid-REQ, data_ok 2 cycles later -> `dreq_valid` held until data_ok, no `done`, `rdata` unchanged, IDLE next cycle.
- Reset asserted in REQ -> `dreq_valid`=0 and state IDLE after that edge; fresh SB at `addr=0x7` then gives `dreq_strobe=8'h80`.

Source files
------------

// File: rtl/mem_access.sv
// mem_access: memory-stage data-bus access unit.
//
// Takes the memory-stage instruction once the misalignment checker has
// produced is_exception. For each access it issues one data-bus request
// (store strobes and lane-shifted data, or a load). It holds the pipeline
// with stall until the bus answers. For loads it returns an aligned,
// sign- or zero-extended result to writeback. Faulting or non-memory
// instructions pass through with no bus activity.
//
// Ports
//   clk, reset         clock, synchronous active-high reset
//   in_valid           memory-stage instruction valid this cycle
//   addr[63:0]         effective address (forwarded unmodified)
//   memread/memwrite   load / store (never both)
//   msize[1:0]         0=1B, 1=2B, 2=4B, 3=8B
//   mem_unsigned       zero-extend the load result
//   wdata[63:0]        right-aligned store data
//   is_exception       misaligned access; suppresses the bus access
//   flush              kill the current memory-stage instruction
//   dreq_*             bus request (valid/addr/size/strobe/data)
//   dresp_data_ok      bus completion
//   dresp_data[63:0]   raw 8-byte read lane
//   stall              hold the memory stage and everything upstream
//   done               one-cycle completion pulse
//   rdata[63:0]        extended load result, valid with done
//   state_o[1:0]       FSM state for observation (0 IDLE, 1 REQ, 2 DONE)
//
// Handshake: a request is presented while dreq_valid is high. All dreq_*
// fields stay stable until the cycle in which dresp_data_ok is sampled
// high. The bus never aborts, so a flushed request still waits for its
// completion and is then discarded.
module mem_access (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [63:0] addr,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [1:0]  msize,
    input  logic        mem_unsigned,
    input  logic [63:0] wdata,
    input  logic        is_exception,
    input  logic        flush,
    output logic        dreq_valid,
    output logic [63:0] dreq_addr,
    output logic [1:0]  dreq_size,
    output logic [7:0]  dreq_strobe,
    output logic [63:0] dreq_data,
    input  logic        dresp_data_ok,
    input  logic [63:0] dresp_data,
    output logic        stall,
    output logic        done,
    output logic [63:0] rdata,
    output logic [1:0]  state_o
);

    localparam logic [1:0] MSIZE1 = 2'd0;
    localparam logic [1:0] MSIZE2 = 2'd1;
    localparam logic [1:0] MSIZE4 = 2'd2;
    localparam logic [1:0] MSIZE8 = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        killed_q, killed_d;
    logic [63:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic [7:0]  strobe_q, strobe_d;
    logic [63:0] data_q, data_d;
    logic        unsigned_q, unsigned_d;
    logic        read_q, read_d;
    logic [63:0] rdata_q, rdata_d;

    logic        launch;
    logic [7:0]  base_strobe;
    logic [7:0]  strobe_new;
    logic [63:0] store_data;
    logic [63:0] load_sh;
    logic [63:0] load_ext;
    logic        sign_bit;

    assign launch = in_valid & (memread | memwrite) & ~is_exception & ~flush
                    & (state_q == S_IDLE);

    // Store lane preparation from the live inputs (used only on launch).
    always_comb begin
        base_strobe = 8'h01;
        case (msize)
            MSIZE1:  base_strobe = 8'h01;
            MSIZE2:  base_strobe = 8'h03;
            MSIZE4:  base_strobe = 8'h0F;
            MSIZE8:  base_strobe = 8'hFF;
            default: base_strobe = 8'h01;
        endcase
        strobe_new = base_strobe << addr[2:0];
        store_data = wdata << {addr[2:0], 3'b000};
    end

    // Load alignment uses the latched address and size; the response lane
    // is only consumed while in REQ.
    always_comb begin
        load_sh  = dresp_data >> {addr_q[2:0], 3'b000};
        sign_bit = 1'b0;
        load_ext = load_sh;
        case (size_q)
            MSIZE1: begin
                sign_bit = ~unsigned_q & load_sh[7];
                load_ext = {{56{sign_bit}}, load_sh[7:0]};
            end
            MSIZE2: begin
                sign_bit = ~unsigned_q & load_sh[15];
                load_ext = {{48{sign_bit}}, load_sh[15:0]};
            end
            MSIZE4: begin
                sign_bit = ~unsigned_q & load_sh[31];
                load_ext = {{32{sign_bit}}, load_sh[31:0]};
            end
            default: begin
                sign_bit = 1'b0;
                load_ext = load_sh;
            end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        killed_d   = killed_q;
        addr_d     = addr_q;
        size_d     = size_q;
        strobe_d   = strobe_q;
        data_d     = data_q;
        unsigned_d = unsigned_q;
        read_d     = read_q;
        rdata_d    = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (launch) begin
                    addr_d     = addr;
                    size_d     = msize;
                    strobe_d   = memwrite ? strobe_new : 8'h00;
                    data_d     = memwrite ? store_data : 64'd0;
                    unsigned_d = mem_unsigned;
                    read_d     = memread;
                    killed_d   = 1'b0;
                    state_d    = S_REQ;
                end
            end
            S_REQ: begin
                if (flush) begin
                    killed_d = 1'b1;
                end
                if (dresp_data_ok) begin
                    killed_d = 1'b0;
                    // A flush arriving together with the completion also kills.
                    if (killed_q | flush) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DONE;
                        if (read_q) begin
                            rdata_d = load_ext;
                        end
                    end
                end
            end
            S_DONE: begin
                // The same instruction is still on the inputs, so never launch here.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            killed_q   <= 1'b0;
            addr_q     <= 64'd0;
            size_q     <= MSIZE1;
            strobe_q   <= 8'h00;
            data_q     <= 64'd0;
            unsigned_q <= 1'b0;
            read_q     <= 1'b0;
            rdata_q    <= 64'd0;
        end else begin
            state_q    <= state_d;
            killed_q   <= killed_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            strobe_q   <= strobe_d;
            data_q     <= data_d;
            unsigned_q <= unsigned_d;
            read_q     <= read_d;
            rdata_q    <= rdata_d;
        end
    end

    assign dreq_valid  = (state_q == S_REQ);
    assign dreq_addr   = addr_q;
    assign dreq_size   = size_q;
    assign dreq_strobe = strobe_q;
    assign dreq_data   = data_q;
    assign stall       = launch | (state_q == S_REQ);
    assign done        = (state_q == S_DONE);
    assign rdata       = rdata_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_mem_access.sv
// Testbench for mem_access: directed scenarios followed by randomized
// accesses, each checked against an arithmetic reference model.
module tb_mem_access;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        in_valid;
    logic [63:0] addr;
    logic        memread;
    logic        memwrite;
    logic [1:0]  msize;
    logic        mem_unsigned;
    logic [63:0] wdata;
    logic        is_exception;
    logic        flush;
    logic        dreq_valid;
    logic [63:0] dreq_addr;
    logic [1:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic [63:0] dreq_data;
    logic        dresp_data_ok;
    logic [63:0] dresp_data;
    logic        stall;
    logic        done;
    logic [63:0] rdata;
    logic [1:0]  state_o;

    mem_access dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .addr          (addr),
        .memread       (memread),
        .memwrite      (memwrite),
        .msize         (msize),
        .mem_unsigned  (mem_unsigned),
        .wdata         (wdata),
        .is_exception  (is_exception),
        .flush         (flush),
        .dreq_valid    (dreq_valid),
        .dreq_addr     (dreq_addr),
        .dreq_size     (dreq_size),
        .dreq_strobe   (dreq_strobe),
        .dreq_data     (dreq_data),
        .dresp_data_ok (dresp_data_ok),
        .dresp_data    (dresp_data),
        .stall         (stall),
        .done          (done),
        .rdata         (rdata),
        .state_o       (state_o)
    );

    // ---------------- scoreboard ----------------
    int          errors = 0;
    int          checks = 0;
    logic [63:0] exp_rdata;
    logic [63:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] model_strobe(input int nbytes, input int off);
        int s;
        s = ((1 << nbytes) - 1) << off;
        return s[7:0];
    endfunction

    function automatic logic [63:0] model_store(input logic [63:0] wd, input int off);
        return wd << (8 * off);
    endfunction

    function automatic logic [63:0] model_load(input logic [63:0] resp, input int off,
                                               input int nbytes, input logic uns);
        logic [63:0] sh, mask, val;
        sh = resp >> (8 * off);
        if (nbytes == 8) return sh;
        mask = (64'd1 << (8 * nbytes)) - 64'd1;
        val  = sh & mask;
        if (!uns && val[8 * nbytes - 1]) val = val | ~mask;
        return val;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        in_valid      = 1'b0;
        memread       = 1'b0;
        memwrite      = 1'b0;
        is_exception  = 1'b0;
        flush         = 1'b0;
        dresp_data_ok = 1'b0;
    endtask

    // One instruction through the memory stage. lat is the cycle (>=1) in
    // which dresp_data_ok is returned; flush_at in [1,lat] pulses flush
    // during REQ, 0 means no flush.
    task automatic run_txn(input string name, input logic rd, input logic wr,
                           input logic [63:0] a, input logic [1:0] sz, input logic uns,
                           input logic [63:0] wd, input logic exc, input logic [63:0] resp,
                           input int lat, input int flush_at);
        int   nb;
        int   off;
        int   stall_cnt;
        bit   launch;
        bit   killed;
        nb        = 1 << sz;
        off       = int'(a[2:0]);
        stall_cnt = 0;
        launch    = (rd || wr) && !exc;
        killed    = (flush_at >= 1) && (flush_at <= lat);

        @(negedge clk);
        in_valid      = 1'b1;
        memread       = rd;
        memwrite      = wr;
        addr          = a;
        msize         = sz;
        mem_unsigned  = uns;
        wdata         = wd;
        is_exception  = exc;
        flush         = 1'b0;
        dresp_data    = resp;
        dresp_data_ok = 1'b0;
        #1;
        check({name, " launch_stall"}, 64'(stall), 64'(launch));
        check({name, " launch_dreq_valid"}, 64'(dreq_valid), 64'd0);
        if (stall) stall_cnt++;

        if (!launch) begin
            // A stray completion outside REQ must be ignored.
            @(negedge clk);
            dresp_data_ok = 1'b1;
            #1;
            check({name, " pass_dreq_valid"}, 64'(dreq_valid), 64'd0);
            check({name, " pass_stall"}, 64'(stall), 64'd0);
            check({name, " pass_done"}, 64'(done), 64'd0);
            @(negedge clk);
            idle_inputs();
            #1;
            check({name, " pass_done2"}, 64'(done), 64'd0);
            check({name, " pass_rdata"}, rdata, exp_rdata);
            return;
        end

        if (rd && !killed) exp_q.push_back(model_load(resp, off, nb, uns));

        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            flush         = (c == flush_at);
            dresp_data_ok = (c == lat);
            #1;
            check({name, " req_valid"}, 64'(dreq_valid), 64'd1);
            check({name, " req_addr"}, dreq_addr, a);
            check({name, " req_size"}, 64'(dreq_size), 64'(sz));
            check({name, " req_strobe"}, 64'(dreq_strobe),
                  wr ? 64'(model_strobe(nb, off)) : 64'd0);
            if (wr) check({name, " req_data"}, dreq_data, model_store(wd, off));
            check({name, " req_done"}, 64'(done), 64'd0);
            if (stall) stall_cnt++;
        end

        @(negedge clk);
        flush         = 1'b0;
        dresp_data_ok = 1'b0;
        if (killed) begin
            in_valid = 1'b0;
            memread  = 1'b0;
            memwrite = 1'b0;
        end
        #1;
        if (!killed && rd) begin
            if (exp_q.size() > 0) exp_rdata = exp_q.pop_front();
        end
        check({name, " end_dreq_valid"}, 64'(dreq_valid), 64'd0);
        check({name, " end_stall"}, 64'(stall), 64'd0);
        check({name, " end_done"}, 64'(done), killed ? 64'd0 : 64'd1);
        check({name, " end_rdata"}, rdata, exp_rdata);
        check({name, " stall_cycles"}, 64'(stall_cnt), 64'(lat + 1));

        @(negedge clk);
        idle_inputs();
        #1;
        check({name, " after_done"}, 64'(done), 64'd0);
        check({name, " after_state"}, 64'(state_o), 64'd0);
        check({name, " after_rdata"}, rdata, exp_rdata);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        idle_inputs();
        addr         = 64'd0;
        msize        = 2'd0;
        mem_unsigned = 1'b0;
        wdata        = 64'd0;
        dresp_data   = 64'd0;
        exp_rdata    = 64'd0;
        reset        = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst dreq_valid", 64'(dreq_valid), 64'd0);
        check("rst stall", 64'(stall), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst rdata", rdata, 64'd0);
        check("rst dreq_addr", dreq_addr, 64'd0);
        check("rst dreq_size", 64'(dreq_size), 64'd0);
        check("rst dreq_strobe", 64'(dreq_strobe), 64'd0);
        check("rst dreq_data", dreq_data, 64'd0);
        check("rst state", 64'(state_o), 64'd0);
        reset = 1'b0;

        // Directed scenarios.
        run_txn("sw", 0, 1, 64'h1004, 2'd2, 0, 64'h11223344, 0, 64'd0, 3, 0);
        run_txn("lb", 1, 0, 64'h2003, 2'd0, 0, 64'd0, 0, 64'h00000000_80000000, 1, 0);
        check("lb value", exp_rdata, 64'hFFFFFFFF_FFFFFF80);
        run_txn("lbu", 1, 0, 64'h2003, 2'd0, 1, 64'd0, 0, 64'h00000000_80000000, 1, 0);
        check("lbu value", exp_rdata, 64'h80);
        run_txn("ld", 1, 0, 64'h3000, 2'd3, 1, 64'd0, 0, 64'hDEADBEEF_CAFEF00D, 2, 0);
        check("ld value", exp_rdata, 64'hDEADBEEF_CAFEF00D);
        run_txn("lh_exc", 1, 0, 64'h4001, 2'd1, 0, 64'd0, 1, 64'hFFFF, 1, 0);
        run_txn("lw_flush", 1, 0, 64'h5004, 2'd2, 0, 64'd0, 0, 64'h12345678_9ABCDEF0, 3, 1);
        run_txn("flush_at_ok", 1, 0, 64'h5008, 2'd3, 0, 64'd0, 0, 64'h55, 2, 2);

        // Reset while a request is outstanding.
        @(negedge clk);
        in_valid = 1'b1;
        memwrite = 1'b1;
        addr     = 64'h6010;
        msize    = 2'd3;
        wdata    = 64'hA5A5_A5A5_A5A5_A5A5;
        @(negedge clk);
        idle_inputs();
        #1;
        check("rstreq in_req", 64'(dreq_valid), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        exp_rdata = 64'd0;
        exp_q.delete();
        check("rstreq dreq_valid", 64'(dreq_valid), 64'd0);
        check("rstreq state", 64'(state_o), 64'd0);
        check("rstreq strobe", 64'(dreq_strobe), 64'd0);
        check("rstreq rdata", rdata, 64'd0);
        check("rstreq stall", 64'(stall), 64'd0);
        run_txn("sb_after_rst", 0, 1, 64'h7, 2'd0, 0, 64'hAB, 0, 64'd0, 2, 0);
        check("sb strobe model", 64'(model_strobe(1, 7)), 64'h80);

        // Randomized accesses.
        for (int i = 0; i < 80; i++) begin
            logic        rd, wr, uns, exc;
            logic [1:0]  sz;
            logic [63:0] a, wd, resp;
            int          lat, fa, kind;
            kind = $urandom_range(0, 9);
            rd   = (kind >= 1) && (kind <= 5);
            wr   = (kind >= 6);
            sz   = 2'($urandom_range(0, 3));
            a    = {$urandom, $urandom};
            a    = a & ~64'((1 << sz) - 1);
            uns  = 1'($urandom_range(0, 1));
            wd   = {$urandom, $urandom};
            resp = {$urandom, $urandom};
            exc  = ($urandom_range(0, 7) == 0);
            lat  = $urandom_range(1, 4);
            fa   = ($urandom_range(0, 5) == 0) ? $urandom_range(1, lat) : 0;
            run_txn("rand", rd, wr, a, sz, uns, wd, exc, resp, lat, fa);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: simulation exceeded time limit");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
